crc_byte_serializer: RTL
========================

// Module: crc_byte_serializer
// PURPOSE
//  Upstream feeder for the serial CRC engine. Accepts parallel bytes on a valid/ready handshake
//  and shifts each one out bit-serially on S_DATA, holding ACTIVE high for exactly DATA_WIDTH cycles.
//  It then waits for the CRC engine to finish its Valid burst, inserts an idle gap and accepts the next byte.
//  Sits between the parallel payload source and the CRC DATA/Active inputs, and consumes CRC Valid.
// PARAMETERS
//  DATA_WIDTH  8   bits per frame; also the length of the ACTIVE burst
//  GAP_CYCLES  2   idle cycles (ACTIVE=0) after a frame completes, before P_READY reasserts; 0 allowed
//  TIMEOUT     32  max cycles in WAIT_CRC before the frame is aborted with CRC_ERR
// PORTS
//  CLK         in   1           clock; all logic on rising edge
//  RST         in   1           reset, synchronous, active-high
//  P_DATA      in   DATA_WIDTH  parallel byte to serialize
//  P_VALID     in   1           P_DATA valid
//  P_READY     out  1           serializer can accept; 1 only in IDLE and RST low
//  CRC_VALID   in   1           Valid output of the CRC engine
//  S_DATA      out  1           serial bit to CRC DATA input (registered)
//  ACTIVE      out  1           to CRC Active input (registered)
//  BUSY        out  1           1 in any state other than IDLE
//  FRAME_DONE  out  1           1-cycle pulse: CRC Valid burst completed normally
//  CRC_ERR     out  1           1-cycle pulse: WAIT_CRC timed out
// BEHAVIOUR
//  Reset (RST=1 at a rising edge, from any state, including mid-shift): state=IDLE, S_DATA=0, ACTIVE=0,
//   FRAME_DONE=0, CRC_ERR=0, and all counters and the shift register cleared. P_READY is forced to 0 while RST=1.
//   A partially shifted frame is discarded and never resumed.
//  States: IDLE, SHIFT, WAIT_CRC, GAP.
//  IDLE: P_READY=1. Transfer occurs when P_VALID & P_READY at edge T.
//   At edge T: latch P_DATA, set S_DATA=bit0, set ACTIVE=1, set bit_cnt=0, and go to SHIFT.
//   P_READY drops in the cycle after T, so back-to-back transfers are impossible.
//  SHIFT: at each edge, bit_cnt++ and S_DATA = next bit (LSB first).
//   ACTIVE stays high for exactly DATA_WIDTH cycles: bits 0..DATA_WIDTH-1 are each held for one full cycle.
//   At the edge where bit_cnt==DATA_WIDTH-1: ACTIVE=0, S_DATA=0, wait_cnt=0, go to WAIT_CRC.
//   Latency: first bit appears 1 cycle after the transfer edge; last bit is held in cycle DATA_WIDTH.
//  WAIT_CRC: ACTIVE=0 and S_DATA=0. A seen flag sets when CRC_VALID is sampled 1.
//   If CRC_VALID is already 1 on the first WAIT_CRC cycle, that counts as seen.
//   When seen=1 and CRC_VALID is sampled 0: FRAME_DONE pulses for 1 cycle, then go to GAP
//   (or to IDLE if GAP_CYCLES==0).
//   wait_cnt increments every cycle. If wait_cnt reaches TIMEOUT-1 without completion, CRC_ERR pulses
//   for 1 cycle and the next state is as above. Completion and timeout on the same edge: completion wins,
//   so only FRAME_DONE fires.
//  GAP: ACTIVE=0 for GAP_CYCLES cycles, then go to IDLE. CRC_VALID is ignored in GAP and IDLE.
//  P_DATA and P_VALID are ignored outside the transfer edge. P_DATA may change freely once latched.
//  Counters are sized clog2(max(DATA_WIDTH,TIMEOUT,GAP_CYCLES)+1) and never wrap inside a state.
// CONFIGURATION
//  CRC_SER_MSB_FIRST_EN defined: bit order is MSB first, so S_DATA emits P_DATA[DATA_WIDTH-1] down to P_DATA[0].
//  CRC_SER_MSB_FIRST_EN undefined (default): LSB first, P_DATA[0] up to P_DATA[DATA_WIDTH-1],
//   which matches the CRC engine's expected input order. No other behaviour changes.
// TESTING
//  1. RST=1 for 2 cycles, then 0 -> during reset ACTIVE=0, S_DATA=0, P_READY=0; first cycle after release
//     P_READY=1 and BUSY=0.
//  2. P_DATA=8'hA5, 1-cycle P_VALID -> ACTIVE high exactly 8 cycles; S_DATA sequence 1,0,1,0,0,1,0,1;
//     P_READY=0 until GAP ends. With MSB_FIRST_EN the sequence is 1,0,1,0,0,1,0,1 and 8'h0F gives 0,0,0,0,1,1,1,1.
//  3. Model CRC_VALID high for 8 cycles, starting 1 cycle after ACTIVE falls -> FRAME_DONE pulses 1 cycle
//     after CRC_VALID falls; P_READY returns after 2 gap cycles.
//  4. CRC_VALID held 0 -> CRC_ERR pulses after exactly 32 WAIT_CRC cycles; FRAME_DONE stays 0;
//     the next byte (8'h3C) still serializes correctly.
//  5. Assert RST at the 4th SHIFT cycle of 8'hFF -> next cycle ACTIVE=0 and S_DATA=0; no FRAME_DONE;
//     a fresh 8'h01 afterwards yields 1 followed by seven 0s.
//  6. Run 10 back-to-back bytes with P_VALID held high (vectors from file) -> every byte is framed with exactly
//     8 ACTIVE cycles, with >=GAP_CYCLES+1 idle cycles between frames and no byte dropped or duplicated.

Source files
------------

// File: rtl/crc_byte_serializer.sv
// -----------------------------------------------------------------------------
// crc_byte_serializer
//
// Upstream feeder for the serial CRC engine. Takes one parallel word on a
// valid/ready handshake, shifts it out bit-serially on s_data while holding
// active high for exactly DATA_WIDTH cycles, then waits for the CRC engine's
// Valid burst to finish (or time out), inserts an idle gap and accepts the
// next word.
//
// Configuration macro:
//   CRC_SER_MSB_FIRST_EN  defined   -> bits leave MSB first
//                         undefined -> bits leave LSB first (CRC engine order)
//
// Parameters:
//   DATA_WIDTH  bits per frame and length of the active burst (>= 2)
//   GAP_CYCLES  idle cycles after a frame before p_ready returns (0 allowed)
//   TIMEOUT     max cycles spent waiting for the CRC Valid burst
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   p_data      parallel word to serialize
//   p_valid     p_data valid
//   p_ready     serializer can accept (idle and not in reset)
//   crc_valid   Valid output of the CRC engine
//   s_data      serial bit to the CRC DATA input (registered)
//   active      to the CRC Active input (registered)
//   busy        high in any state other than idle (registered)
//   frame_done  1-cycle pulse: CRC Valid burst completed
//   crc_err     1-cycle pulse: CRC Valid burst did not complete in time
// -----------------------------------------------------------------------------
module crc_byte_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  p_valid,
  output logic                  p_ready,
  input  logic                  crc_valid,
  output logic                  s_data,
  output logic                  active,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  crc_err
);

  localparam int MAX_AB = (DATA_WIDTH > TIMEOUT) ? DATA_WIDTH : TIMEOUT;
  localparam int MAX_V  = (MAX_AB > GAP_CYCLES) ? MAX_AB : GAP_CYCLES;
  localparam int CNT_W  = $clog2(MAX_V + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // With no gap configured the wait state returns straight to idle.
  localparam state_t POST_WAIT = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

`ifdef CRC_SER_MSB_FIRST_EN
  // Bit that leaves first from a word still to be sent.
  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] d);
    head_bit = d[DATA_WIDTH-1];
  endfunction

  // Drop the bit just sent so the next one is at the head.
  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] d);
    advance = {d[DATA_WIDTH-2:0], 1'b0};
  endfunction
`else
  // Bit that leaves first from a word still to be sent.
  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] d);
    head_bit = d[0];
  endfunction

  // Drop the bit just sent so the next one is at the head.
  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] d);
    advance = {1'b0, d[DATA_WIDTH-1:1]};
  endfunction
`endif

  state_t                  state_r, next_state_s;
  logic [DATA_WIDTH-1:0]   shift_r, shift_nxt_s, shift_adv_s;
  logic [CNT_W-1:0]        bit_cnt_r, bit_cnt_nxt_s;
  logic [CNT_W-1:0]        wait_cnt_r, wait_cnt_nxt_s;
  logic [CNT_W-1:0]        gap_cnt_r, gap_cnt_nxt_s;
  logic                    seen_r, seen_nxt_s;
  logic                    s_data_r, s_data_nxt_s;
  logic                    active_r, active_nxt_s;
  logic                    frame_done_r, frame_done_nxt_s;
  logic                    crc_err_r, crc_err_nxt_s;
  logic                    busy_r;
  logic                    ready_r;

  logic accept_s, last_bit_s, crc_done_s, crc_tmo_s, gap_end_s;

  assign accept_s    = (state_r == ST_IDLE) && p_valid;
  assign last_bit_s  = (state_r == ST_SHIFT) && (bit_cnt_r == BIT_LAST);
  // Burst complete once Valid has been seen and is now low again.
  assign crc_done_s  = (state_r == ST_WAIT) && seen_r && !crc_valid;
  // Completion on the final wait cycle takes priority over the timeout.
  assign crc_tmo_s   = (state_r == ST_WAIT) && !crc_done_s && (wait_cnt_r == WAIT_LAST);
  assign gap_end_s   = (state_r == ST_GAP) && (gap_cnt_r == GAP_LAST);
  assign shift_adv_s = advance(shift_r);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = ST_SHIFT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_bit_s) begin
          next_state_s = ST_WAIT;
        end else begin
          next_state_s = ST_SHIFT;
        end
      end
      ST_WAIT: begin
        if (crc_done_s || crc_tmo_s) begin
          next_state_s = POST_WAIT;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_GAP: begin
        if (gap_end_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_GAP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, shift register and counters.
  always_comb begin
    shift_nxt_s      = shift_r;
    bit_cnt_nxt_s    = bit_cnt_r;
    wait_cnt_nxt_s   = wait_cnt_r;
    gap_cnt_nxt_s    = gap_cnt_r;
    seen_nxt_s       = seen_r;
    s_data_nxt_s     = 1'b0;
    active_nxt_s     = 1'b0;
    frame_done_nxt_s = 1'b0;
    crc_err_nxt_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          shift_nxt_s   = p_data;
          s_data_nxt_s  = head_bit(p_data);
          active_nxt_s  = 1'b1;
          bit_cnt_nxt_s = CNT_ZERO;
        end else begin
          shift_nxt_s   = shift_r;
        end
      end
      ST_SHIFT: begin
        if (last_bit_s) begin
          wait_cnt_nxt_s = CNT_ZERO;
          seen_nxt_s     = 1'b0;
        end else begin
          shift_nxt_s    = shift_adv_s;
          s_data_nxt_s   = head_bit(shift_adv_s);
          active_nxt_s   = 1'b1;
          bit_cnt_nxt_s  = bit_cnt_r + CNT_ONE;
        end
      end
      ST_WAIT: begin
        if (crc_done_s) begin
          frame_done_nxt_s = 1'b1;
          gap_cnt_nxt_s    = CNT_ZERO;
        end else if (crc_tmo_s) begin
          crc_err_nxt_s    = 1'b1;
          gap_cnt_nxt_s    = CNT_ZERO;
        end else begin
          wait_cnt_nxt_s   = wait_cnt_r + CNT_ONE;
          seen_nxt_s       = seen_r | crc_valid;
        end
      end
      ST_GAP: begin
        if (gap_end_s) begin
          gap_cnt_nxt_s = CNT_ZERO;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r + CNT_ONE;
        end
      end
      default: begin
        shift_nxt_s = shift_r;
      end
    endcase
  end

  // Datapath and output registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r      <= '0;
      bit_cnt_r    <= CNT_ZERO;
      wait_cnt_r   <= CNT_ZERO;
      gap_cnt_r    <= CNT_ZERO;
      seen_r       <= 1'b0;
      s_data_r     <= 1'b0;
      active_r     <= 1'b0;
      frame_done_r <= 1'b0;
      crc_err_r    <= 1'b0;
      busy_r       <= 1'b0;
      ready_r      <= 1'b1;
    end else begin
      shift_r      <= shift_nxt_s;
      bit_cnt_r    <= bit_cnt_nxt_s;
      wait_cnt_r   <= wait_cnt_nxt_s;
      gap_cnt_r    <= gap_cnt_nxt_s;
      seen_r       <= seen_nxt_s;
      s_data_r     <= s_data_nxt_s;
      active_r     <= active_nxt_s;
      frame_done_r <= frame_done_nxt_s;
      crc_err_r    <= crc_err_nxt_s;
      busy_r       <= (next_state_s != ST_IDLE);
      ready_r      <= (next_state_s == ST_IDLE);
    end
  end

  // ready_r mirrors the idle state; reset must also hold p_ready low.
  assign p_ready    = ready_r & ~rst;
  assign s_data     = s_data_r;
  assign active     = active_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign crc_err    = crc_err_r;

endmodule
